// File: rtl/mips_mc_controller.sv
// mips_mc_controller
// Multi-cycle control FSM for the IITK-MIPS datapath. One instruction at a
// time is sequenced through IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB.
// The controller drives the shared instruction/data memory port, PC, IR,
// register file and the 5-bit-select ALU.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   run                 permits fetching a new instruction
//   instr               IR contents (valid from DECODE onward)
//   zero, lt            ALU zero flag, unsigned rs < rt
//   mem_ack             memory completes the current access this cycle
//   mem_req/we/sel      memory request, write strobe, address source
//   ir_we, pc_we        IR / PC load enables
//   pc_src              0 PC+4, 1 branch target, 2 jump target, 3 rs
//   alu_sel/swap        ALU operation code and operand swap
//   alu_src_b, imm_zext B operand = immediate, zero-extend immediate
//   rf_we/dst/wsrc      register-file write, destination, data source
//   retire              one-cycle pulse per completed instruction
//   illegal, bus_err    sticky error flags (cleared only by reset)
//   state_o             current state encoding
//
// Build option
//   MC_CTRL_TIMEOUT_EN  enables the TIMEOUT_W-bit memory-ack watchdog; when
//                       undefined the controller waits forever and bus_err=0.
module mips_mc_controller #(
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        lt,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [4:0]  alu_sel,
   output logic        alu_swap,
   output logic        alu_src_b,
   output logic        imm_zext,
   output logic        rf_we,
   output logic [1:0]  rf_dst,
   output logic [1:0]  rf_wsrc,
   output logic        retire,
   output logic        illegal,
   output logic        bus_err,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_BLE   = 6'd6;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b01000;
   localparam logic [4:0] ALU_OR  = 5'b01001;
   localparam logic [4:0] ALU_GT  = 5'b01110;

   state_t     state, state_nxt, after_retire;
   logic [5:0] opcode, funct;
   logic       is_jr, r_alu, i_ok, br_taken;
   logic       illegal_set, timeout;
   logic       unused_instr;

   assign opcode       = instr[31:26];
   assign funct        = instr[5:0];
   assign unused_instr = ^instr[25:6];
   assign state_o      = state;

   assign is_jr = (opcode == OP_RTYPE) && (funct == 6'd8);
   assign r_alu = (opcode == OP_RTYPE) &&
                  (funct inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42});
   assign i_ok  = opcode inside {OP_BEQ, OP_BNE, OP_BLE, OP_ADDI, OP_ADDIU,
                                 OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
   assign br_taken = ((opcode == OP_BEQ) &&  zero) ||
                     ((opcode == OP_BNE) && !zero) ||
                     ((opcode == OP_BLE) &&  lt);

   // run is only consulted on the retire cycle
   assign after_retire = run ? S_FETCH : S_IDLE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)            illegal <= 1'b0;
      else if (illegal_set) illegal <= 1'b1;
   end

`ifdef MC_CTRL_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   // timeout fires on the cycle whose increment would reach all-ones
   localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   logic [TIMEOUT_W-1:0] wd;
   logic                 mem_wait;

   // every entry into FETCH/MEM comes from a non-memory state or an acked
   // access, so clearing outside of a pending access clears on entry
   assign mem_wait = ((state == S_FETCH) || (state == S_MEM)) && !mem_ack;
   assign timeout  = mem_wait && (wd == WD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         wd <= '0;
      else if (mem_wait) wd <= wd + WD_ONE;
      else               wd <= '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        bus_err <= 1'b0;
      else if (timeout) bus_err <= 1'b1;
   end
`else
   localparam int unused_timeout_w = TIMEOUT_W;
   assign timeout = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      illegal_set = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_sel     = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 2'd0;
      alu_sel     = ALU_ADD;
      alu_swap    = 1'b0;
      alu_src_b   = 1'b0;
      imm_zext    = 1'b0;
      rf_we       = 1'b0;
      rf_dst      = 2'd0;
      rf_wsrc     = 2'd0;
      retire      = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout) begin
               state_nxt = S_TRAP;
            end
         end
         S_DECODE: begin
            if ((opcode == OP_J) || (opcode == OP_JAL)) begin
               pc_we     = 1'b1;
               pc_src    = 2'd2;
               retire    = 1'b1;
               state_nxt = after_retire;
               // link value is the PC already incremented in FETCH
               if (opcode == OP_JAL) begin
                  rf_we   = 1'b1;
                  rf_dst  = 2'd2;
                  rf_wsrc = 2'd2;
               end
            end else if (is_jr) begin
               pc_we     = 1'b1;
               pc_src    = 2'd3;
               retire    = 1'b1;
               state_nxt = after_retire;
            end else if (r_alu || i_ok) begin
               state_nxt = S_EXEC;
            end else begin
               illegal_set = 1'b1;
               state_nxt   = S_TRAP;
            end
         end
         S_EXEC: begin
            state_nxt = S_WB;
            if (opcode == OP_RTYPE) begin
               case (funct)
                  6'd34, 6'd35: alu_sel = ALU_SUB;
                  6'd36:        alu_sel = ALU_AND;
                  6'd37:        alu_sel = ALU_OR;
                  6'd42: begin
                     alu_sel  = ALU_GT;
                     alu_swap = 1'b1;
                  end
                  default:      alu_sel = ALU_ADD;
               endcase
            end else begin
               alu_src_b = 1'b1;
               case (opcode)
                  OP_SLTI: begin
                     alu_sel  = ALU_GT;
                     alu_swap = 1'b1;
                  end
                  OP_ANDI: begin
                     alu_sel  = ALU_AND;
                     imm_zext = 1'b1;
                  end
                  OP_ORI: begin
                     alu_sel  = ALU_OR;
                     imm_zext = 1'b1;
                  end
                  OP_BEQ, OP_BNE, OP_BLE: begin
                     alu_src_b = 1'b0;
                     alu_sel   = ALU_SUB;
                     pc_we     = br_taken;
                     pc_src    = br_taken ? 2'd1 : 2'd0;
                     retire    = 1'b1;
                     state_nxt = after_retire;
                  end
                  OP_LW, OP_SW: state_nxt = S_MEM;
                  default: ;
               endcase
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = (opcode == OP_SW);
            if (mem_ack) begin
               if (opcode == OP_SW) begin
                  retire    = 1'b1;
                  state_nxt = after_retire;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (timeout) begin
               state_nxt = S_TRAP;
            end
         end
         S_WB: begin
            rf_we     = 1'b1;
            rf_dst    = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
            rf_wsrc   = (opcode == OP_LW)    ? 2'd1 : 2'd0;
            retire    = 1'b1;
            state_nxt = after_retire;
         end
         S_TRAP: ;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [25:0] ALL0 = '0;

   logic        clk = 1'b0;
   logic        reset, run, zero, lt, mem_ack;
   logic [31:0] instr;
   logic        mem_req, mem_we, mem_sel, ir_we, pc_we;
   logic [1:0]  pc_src;
   logic [4:0]  alu_sel;
   logic        alu_swap, alu_src_b, imm_zext, rf_we;
   logic [1:0]  rf_dst, rf_wsrc;
   logic        retire, illegal, bus_err;
   logic [2:0]  state_o;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mips_mc_controller #(.TIMEOUT_W(8)) dut (
      .clk(clk), .reset(reset), .run(run), .instr(instr), .zero(zero), .lt(lt),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_sel(alu_sel),
      .alu_swap(alu_swap), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
      .rf_we(rf_we), .rf_dst(rf_dst), .rf_wsrc(rf_wsrc), .retire(retire),
      .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
   );

   // expected output vector, same field order as snap()
   function automatic logic [25:0] cv(input logic [2:0] st, input logic mreq, input logic mwe,
         input logic msel, input logic irwe, input logic pcwe, input logic [1:0] pcs,
         input logic [4:0] asel, input logic swp, input logic srcb, input logic zx,
         input logic rfwe, input logic [1:0] dst, input logic [1:0] wsrc,
         input logic ret, input logic ill, input logic berr);
      return {st, mreq, mwe, msel, irwe, pcwe, pcs, asel, swp, srcb, zx, rfwe, dst, wsrc,
              ret, ill, berr};
   endfunction

   function automatic logic [25:0] snap();
      return {state_o, mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, alu_sel, alu_swap,
              alu_src_b, imm_zext, rf_we, rf_dst, rf_wsrc, retire, illegal, bus_err};
   endfunction

   function automatic logic [31:0] mkr(input logic [5:0] f);
      return {6'd0, 5'd4, 5'd5, 5'd6, 5'd0, f};
   endfunction

   function automatic logic [31:0] mki(input logic [5:0] op);
      return {op, 5'd4, 5'd5, 16'h8001};
   endfunction

   task automatic test_reset();
      reset = 1'b1; run = 1'b1; mem_ack = 1'b1; instr = mkr(6'd32); zero = 1'b0; lt = 1'b0;
      #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL reset_hold: got %h want %h", snap(), ALL0); end
      @(negedge clk); #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL reset_hold2: got %h want %h", snap(), ALL0); end
      reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      logic [25:0] e;
      int rc = 0;
      run = 1'b1; mem_ack = 1'b1; instr = mkr(6'd32);
      #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL add_idle: got %h want %h", snap(), ALL0); end
      @(negedge clk); #1; rc += int'(retire); vecs++;
      e = cv(3'd1,H,L,L,H,H,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL add_fetch: got %h want %h", snap(), e); end
      @(negedge clk); #1; rc += int'(retire); vecs++;
      e = cv(3'd2,L,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL add_decode: got %h want %h", snap(), e); end
      @(negedge clk); #1; rc += int'(retire); vecs++;
      e = cv(3'd3,L,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL add_exec: got %h want %h", snap(), e); end
      @(negedge clk); run = 1'b0; #1; rc += int'(retire); vecs++;
      e = cv(3'd5,L,L,L,L,L,2'd0,5'd0,L,L,L,H,2'd1,2'd0,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL add_wb: got %h want %h", snap(), e); end
      @(negedge clk); #1; rc += int'(retire); vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL add_back_idle: got %h want %h", snap(), ALL0); end
      vecs++;
      if (rc !== 1) begin errs++; $display("FAIL add_retire_count: got %0d want 1", rc); end
      mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_alu_ops();
      logic [40:0] tbl [11];
      logic [25:0] e;
      // {instr, alu_sel, swap, src_b, zext, rd-destination}
      tbl = '{ {mkr(6'd34), 5'd1,  4'b0001}, {mkr(6'd35), 5'd1,  4'b0001},
               {mkr(6'd36), 5'd8,  4'b0001}, {mkr(6'd37), 5'd9,  4'b0001},
               {mkr(6'd42), 5'd14, 4'b1001}, {mkr(6'd33), 5'd0,  4'b0001},
               {mki(6'd8),  5'd0,  4'b0100}, {mki(6'd9),  5'd0,  4'b0100},
               {mki(6'd10), 5'd14, 4'b1100}, {mki(6'd12), 5'd8,  4'b0110},
               {mki(6'd13), 5'd9,  4'b0110} };
      run = 1'b1; mem_ack = 1'b1; instr = tbl[0][40:9];
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         instr = tbl[i][40:9];
         @(negedge clk);
         @(negedge clk); #1; vecs++;
         e = cv(3'd3,L,L,L,L,L,2'd0,tbl[i][8:4],tbl[i][3],tbl[i][2],tbl[i][1],L,2'd0,2'd0,L,L,L);
         if (snap() !== e) begin errs++; $display("FAIL alu_exec[%0d]: got %h want %h", i, snap(), e); end
         @(negedge clk); #1; vecs++;
         e = cv(3'd5,L,L,L,L,L,2'd0,5'd0,L,L,L,H,{1'b0,tbl[i][0]},2'd0,H,L,L);
         if (snap() !== e) begin errs++; $display("FAIL alu_wb[%0d]: got %h want %h", i, snap(), e); end
         @(negedge clk);
      end
      instr = mki(6'd2); run = 1'b0;
      @(negedge clk); #1; vecs++;
      e = cv(3'd2,L,L,L,L,H,2'd2,5'd0,L,L,L,L,2'd0,2'd0,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL j_decode: got %h want %h", snap(), e); end
      @(negedge clk); #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL j_idle: got %h want %h", snap(), ALL0); end
      mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw_wait();
      logic [25:0] e;
      run = 1'b1; mem_ack = 1'b1; instr = mki(6'd35);
      @(negedge clk);
      @(negedge clk); mem_ack = 1'b0;
      @(negedge clk); #1; vecs++;
      e = cv(3'd3,L,L,L,L,L,2'd0,5'd0,L,H,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL lw_exec: got %h want %h", snap(), e); end
      for (int w = 0; w < 4; w++) begin
         @(negedge clk); mem_ack = (w == 3); #1; vecs++;
         e = cv(3'd4,H,L,H,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
         if (snap() !== e) begin errs++; $display("FAIL lw_mem[%0d]: got %h want %h", w, snap(), e); end
      end
      @(negedge clk); run = 1'b0; #1; vecs++;
      e = cv(3'd5,L,L,L,L,L,2'd0,5'd0,L,L,L,H,2'd0,2'd1,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL lw_wb: got %h want %h", snap(), e); end
      @(negedge clk); #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL lw_idle: got %h want %h", snap(), ALL0); end
      mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_branch();
      logic [25:0] e;
      run = 1'b1; mem_ack = 1'b1; zero = 1'b1; lt = 1'b0; instr = mki(6'd4);
      @(negedge clk);
      @(negedge clk); #1; vecs++;
      e = cv(3'd2,L,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL beq_decode: got %h want %h", snap(), e); end
      @(negedge clk); #1; vecs++;
      e = cv(3'd3,L,L,L,L,H,2'd1,5'd1,L,L,L,L,2'd0,2'd0,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL beq_taken: got %h want %h", snap(), e); end
      @(negedge clk); instr = mki(6'd5);
      @(negedge clk);
      @(negedge clk); #1; vecs++;
      e = cv(3'd3,L,L,L,L,L,2'd0,5'd1,L,L,L,L,2'd0,2'd0,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL bne_not_taken: got %h want %h", snap(), e); end
      @(negedge clk); instr = mki(6'd6); zero = 1'b0; lt = 1'b1;
      @(negedge clk);
      @(negedge clk); #1; vecs++;
      e = cv(3'd3,L,L,L,L,H,2'd1,5'd1,L,L,L,L,2'd0,2'd0,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL ble_taken: got %h want %h", snap(), e); end
      @(negedge clk); instr = mki(6'd43); lt = 1'b0;
      @(negedge clk);
      @(negedge clk); #1; vecs++;
      e = cv(3'd3,L,L,L,L,L,2'd0,5'd0,L,H,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL sw_exec: got %h want %h", snap(), e); end
      @(negedge clk); run = 1'b0; #1; vecs++;
      e = cv(3'd4,H,H,H,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL sw_mem: got %h want %h", snap(), e); end
      @(negedge clk); #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL sw_idle: got %h want %h", snap(), ALL0); end
      mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_jal();
      logic [25:0] e;
      run = 1'b1; mem_ack = 1'b1; instr = {6'd3, 26'h0000040};
      @(negedge clk);
      @(negedge clk); #1; vecs++;
      e = cv(3'd2,L,L,L,L,H,2'd2,5'd0,L,L,L,H,2'd2,2'd2,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL jal_decode: got %h want %h", snap(), e); end
      @(negedge clk); instr = mkr(6'd8); run = 1'b0; #1; vecs++;
      e = cv(3'd1,H,L,L,H,H,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL jal_refetch: got %h want %h", snap(), e); end
      @(negedge clk); #1; vecs++;
      e = cv(3'd2,L,L,L,L,H,2'd3,5'd0,L,L,L,L,2'd0,2'd0,H,L,L);
      if (snap() !== e) begin errs++; $display("FAIL jr_decode: got %h want %h", snap(), e); end
      @(negedge clk); #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL jr_idle: got %h want %h", snap(), ALL0); end
      mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      logic [25:0] e;
      run = 1'b1; mem_ack = 1'b0; instr = mkr(6'd32);
      @(negedge clk); #1; vecs++;
      e = cv(3'd1,H,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL fetch_wait: got %h want %h", snap(), e); end
      #2 reset = 1'b1;
      #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL reset_mid_access: got %h want %h", snap(), ALL0); end
      @(negedge clk); reset = 1'b0; run = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [25:0] e;
      int n;
      run = 1'b1; mem_ack = 1'b0; instr = mkr(6'd32);
      @(negedge clk); run = 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
      n = 1;
      while ((state_o !== 3'd6) && (n < 400)) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (n !== 256) begin errs++; $display("FAIL timeout_cycles: got %0d want 256", n); end
      #1; vecs++;
      e = cv(3'd6,L,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,H);
      if (snap() !== e) begin errs++; $display("FAIL timeout_trap: got %h want %h", snap(), e); end
`else
      n = 0;
      repeat (299) begin
         @(negedge clk);
         n++;
      end
      #1; vecs++;
      e = cv(3'd1,H,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL no_timeout_after_%0d: got %h want %h", n, snap(), e); end
`endif
      #1 reset = 1'b1;
      #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL timeout_reset: got %h want %h", snap(), ALL0); end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_illegal(input logic [31:0] ins, input int hold);
      logic [25:0] e;
      run = 1'b1; mem_ack = 1'b1; instr = ins;
      @(negedge clk);
      @(negedge clk); #1; vecs++;
      e = cv(3'd2,L,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,L,L);
      if (snap() !== e) begin errs++; $display("FAIL illegal_decode %h: got %h want %h", ins, snap(), e); end
      @(negedge clk);
      e = cv(3'd6,L,L,L,L,L,2'd0,5'd0,L,L,L,L,2'd0,2'd0,L,H,L);
      for (int c = 0; c < hold; c++) begin
         mem_ack = c[0];
         #1; vecs++;
         if (snap() !== e) begin errs++; $display("FAIL trap_hold[%0d] %h: got %h want %h", c, ins, snap(), e); end
         @(negedge clk);
      end
      #2 reset = 1'b1;
      #1; vecs++;
      if (snap() !== ALL0) begin errs++; $display("FAIL trap_reset %h: got %h want %h", ins, snap(), ALL0); end
      @(negedge clk); reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; zero = 1'b0; lt = 1'b0; mem_ack = 1'b0; instr = '0;
      @(negedge clk);
      test_reset();
      test_add();
      test_alu_ops();
      test_lw_wait();
      test_branch();
      test_jal();
      test_reset_mid_access();
      test_timeout();
      test_illegal({6'd7, 26'h0}, 20);
      test_illegal(mkr(6'd0), 3);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got timeout want completion");
      $fatal(1);
   end

endmodule
